// File: rtl/store_control.sv
// Store-side control: aligns SB/SH/SW data into byte lanes, drives registered DMEM/IMEM
// write ports, and queues IO-region stores in a FIFO. Optional counters behind STORE_STATS_EN.
module store_control #(
    parameter int IO_DEPTH = 4,
    parameter int MEM_AW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [2:0]        st_funct3,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic              pc_in_bios,
    output logic              stall,
    output logic [3:0]        dmem_we,
    output logic [MEM_AW-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    output logic [3:0]        imem_we,
    output logic [MEM_AW-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              io_valid,
    input  logic              io_ready,
    output logic [31:0]       io_addr,
    output logic [3:0]        io_be,
    output logic [31:0]       io_data,
    output logic              misalign_err,
    output logic              misalign_sticky,
    output logic [31:0]       io_store_count,
    output logic [31:0]       mem_store_count
);
    localparam int PW = $clog2(IO_DEPTH);

    logic [3:0]  be;
    logic [31:0] data;
    logic        f3_ok, aligned;

    always_comb begin
        be      = 4'b0000;
        data    = 32'd0;
        f3_ok   = 1'b1;
        aligned = 1'b1;
        case (st_funct3)
            3'b000: begin
                be   = 4'b0001 << st_addr[1:0];
                data = {4{st_data[7:0]}};
            end
            3'b001: begin
                aligned = ~st_addr[0];
                be      = 4'b0011 << st_addr[1:0];
                data    = {2{st_data[15:0]}};
            end
            3'b010: begin
                aligned = (st_addr[1:0] == 2'b00);
                be      = 4'b1111;
                data    = st_data;
            end
            default: f3_ok = 1'b0;
        endcase
    end

    logic [3:0] region;
    logic       good, is_io, full, push, pop, misalign, dmem_hit, imem_hit;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;

    assign region   = st_addr[31:28];
    assign good     = st_valid && f3_ok && aligned;
    assign is_io    = (region == 4'b1000);
    assign full     = (count_q == (PW+1)'(IO_DEPTH));
    // Stall ignores io_ready so there is no combinational path from the IO block.
    assign stall    = good && is_io && full;
    assign push     = good && is_io && !full;
    assign pop      = io_valid && io_ready;
    assign misalign = st_valid && f3_ok && !aligned;
    assign dmem_hit = good && (region == 4'b0001 || region == 4'b0011);
    assign imem_hit = good && pc_in_bios && (region == 4'b0010 || region == 4'b0011);

    logic [3:0]        dmem_we_q, imem_we_q;
    logic [MEM_AW-1:0] dmem_addr_q, imem_addr_q;
    logic [31:0]       dmem_din_q, imem_din_q;
    logic              mis_q, sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_we_q   <= 4'b0000;
            imem_we_q   <= 4'b0000;
            dmem_addr_q <= '0;
            imem_addr_q <= '0;
            dmem_din_q  <= 32'd0;
            imem_din_q  <= 32'd0;
            mis_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            dmem_we_q <= dmem_hit ? be : 4'b0000;
            imem_we_q <= imem_hit ? be : 4'b0000;
            if (dmem_hit) begin
                dmem_addr_q <= st_addr[MEM_AW+1:2];
                dmem_din_q  <= data;
            end
            if (imem_hit) begin
                imem_addr_q <= st_addr[MEM_AW+1:2];
                imem_din_q  <= data;
            end
            mis_q <= misalign;
            if (misalign) sticky_q <= 1'b1;
        end
    end

    assign dmem_we         = dmem_we_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_din        = dmem_din_q;
    assign imem_we         = imem_we_q;
    assign imem_addr       = imem_addr_q;
    assign imem_din        = imem_din_q;
    assign misalign_err    = mis_q;
    assign misalign_sticky = sticky_q;

    logic [31:0] fifo_addr_q [IO_DEPTH];
    logic [3:0]  fifo_be_q   [IO_DEPTH];
    logic [31:0] fifo_data_q [IO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= st_addr;
            fifo_be_q[wr_ptr_q]   <= be;
            fifo_data_q[wr_ptr_q] <= data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign io_valid = (count_q != '0);
    assign io_addr  = fifo_addr_q[rd_ptr_q];
    assign io_be    = fifo_be_q[rd_ptr_q];
    assign io_data  = fifo_data_q[rd_ptr_q];

`ifdef STORE_STATS_EN
    logic [31:0] mem_cnt_q, io_cnt_q;

    // A store hitting both DMEM and IMEM counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt_q <= 32'd0;
            io_cnt_q  <= 32'd0;
        end else begin
            if (dmem_hit || imem_hit) mem_cnt_q <= mem_cnt_q + 32'd1;
            if (pop)                  io_cnt_q  <= io_cnt_q + 32'd1;
        end
    end

    assign mem_store_count = mem_cnt_q;
    assign io_store_count  = io_cnt_q;
`else
    assign mem_store_count = 32'd0;
    assign io_store_count  = 32'd0;
`endif

endmodule
